// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster-scan signal bundle between timing generator and pixel/DAC logic
interface vga_timing_gen_if;
   logic       pix_en;
   logic [9:0] x;
   logic [9:0] y;
   logic       hsync;
   logic       vsync;
   logic       video_on;
   logic       vga_blank_n;
   logic       vga_sync_n;
   logic       vga_clk;
   logic       frame_tick;

   modport master (
      output pix_en, x, y, hsync, vsync, video_on,
             vga_blank_n, vga_sync_n, vga_clk, frame_tick
   );

   modport slave (
      input  pix_en, x, y, hsync, vsync, video_on,
             vga_blank_n, vga_sync_n, vga_clk, frame_tick
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel divider, x/y counters, delayed sync/blank, frame tick
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int DELAY    = 1
) (
   input  logic              clk,
   input  logic              reset,
   vga_timing_gen_if.master  vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
   localparam logic [2:0] DIV_HALF = 3'(CLK_DIV / 2);
   localparam bit         HAS_VCLK = (CLK_DIV > 1);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] V_VIS_M1 = 10'(V_ACTIVE - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [2:0] div;
   logic [2:0] div_next;
   logic       pix_en;
   logic       vga_clk_q;
   logic [9:0] x_q;
   logic [9:0] y_q;
   logic       tick_q;

   assign pix_en   = (div == DIV_LAST);
   assign div_next = pix_en ? 3'd0 : div + 3'd1;

   // vga_clk is registered from the next divider value so it tracks div in the same cycle;
   // with no divider there is no sub-pixel phase to show, so it stays low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div       <= 3'd0;
         vga_clk_q <= 1'b0;
      end else begin
         div       <= div_next;
         vga_clk_q <= HAS_VCLK && (div_next >= DIV_HALF);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q    <= 10'd0;
         y_q    <= 10'd0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= pix_en && (x_q == H_LAST) && (y_q == V_VIS_M1);
         if (pix_en) begin
            if (x_q == H_LAST) begin
               x_q <= 10'd0;
               y_q <= (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
               x_q <= x_q + 10'd1;
            end
         end
      end
   end

   logic       hs_raw;
   logic       vs_raw;
   logic       vid_raw;
   logic [2:0] raw_vec;

   assign hs_raw  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
   assign vs_raw  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
   assign vid_raw = (x_q < H_VIS) && (y_q < V_VIS);
   assign raw_vec = {hs_raw, vs_raw, vid_raw};

   // Delay line runs every clk so sync/blank line up with the registered colour stage.
   logic [DELAY-1:0][2:0] pipe;

   generate
      if (DELAY > 1) begin : g_pipe_multi
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pipe <= '0;
            else       pipe <= {pipe[DELAY-2:0], raw_vec};
         end
      end else begin : g_pipe_single
         always_ff @(posedge clk or posedge reset) begin
            if (reset) pipe <= '0;
            else       pipe <= raw_vec;
         end
      end
   endgenerate

   logic [2:0] dly;
   assign dly = pipe[DELAY-1];

   assign vga.pix_en      = pix_en;
   assign vga.x           = x_q;
   assign vga.y           = y_q;
   assign vga.hsync       = dly[2] ? SYNC_POL : ~SYNC_POL;
   assign vga.vsync       = dly[1] ? SYNC_POL : ~SYNC_POL;
   assign vga.video_on    = dly[0];
   assign vga.vga_blank_n = dly[0];
   assign vga.vga_sync_n  = 1'b1;
   assign vga.vga_clk     = vga_clk_q;
   assign vga.frame_tick  = tick_q;
endmodule
